fetch_bus_responder: RTL and testbench

FETCH_BUS_RESPONDER -- requirements
Module: fetch_bus_responder

---
 rtl/fetch_bus_pkg.sv | 15 +
 rtl/fetch_bus_responder.sv | 122 ++++++++++++
 tb/tb_fetch_bus_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_bus_pkg.sv
// Shared definitions for the instruction-fetch bus responder: state encoding
// and default timing parameters.
package fetch_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_MEM  = 2'b10,
        ST_RESP = 2'b11
    } fetch_state_e;

    localparam int unsigned FB_WAIT_STATES = 2;
    localparam int unsigned FB_TIMEOUT     = 64;

endpackage

// File: rtl/fetch_bus_responder.sv
// Fetch-bus responder: accepts one instruction fetch at a time, inserts wait
// states, runs a single memory read with timeout, and returns a one-cycle response.
module fetch_bus_responder
    import fetch_bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = FB_WAIT_STATES,
    parameter int unsigned TIMEOUT     = FB_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_en,
    input  logic [31:0] bus_addr,
    output logic        bus_ready,
    output logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    fetch_state_e state_q, state_d;
    logic [3:0]   wait_cnt_q, wait_cnt_d;
    logic [7:0]   to_cnt_q, to_cnt_d;
    logic [31:2]  addr_q, addr_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus_en) begin
                    addr_d   = bus_addr[31:2];
                    to_cnt_d = '0;
                    if (bus_addr[1:0] != 2'b00) begin
                        // Misaligned fetches are answered with an error, never sent to memory
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_MEM;
                    end else begin
                        wait_cnt_d = 4'(WAIT_STATES);
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (!bus_en)
                    state_d = ST_IDLE;
                else if (wait_cnt_q == 4'd1)
                    state_d = ST_MEM;
            end
            ST_MEM: begin
                to_cnt_d = to_cnt_q + 8'd1;
                // An ack always completes the memory side, even if the initiator has left
                if (mem_ack) begin
                    if (bus_en) begin
                        rdata_d = mem_rdata;
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (to_cnt_q == 8'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus_ready = 1'b0;
        bus_rdata = '0;
        bus_err   = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        unique case (state_q)
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
            end
            ST_RESP: begin
                bus_ready = 1'b1;
                bus_rdata = rdata_q;
                bus_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_bus_responder.sv
// Bench for fetch_bus_responder: directed vector table, reset corner case,
// and random transactions checked against a transaction-level latency model.
module tb_fetch_bus_responder;

    localparam int WS  = 2;
    localparam int TO  = 8;
    localparam int RUN = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_en;
    logic [31:0] bus_addr;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // drop: cycle (1 = first cycle after the capture edge) in which bus_en is low, 0 = never
    typedef struct {
        logic [31:0] addr;
        int          ack_dly;
        int          drop;
        logic [31:0] rdata;
        int          exp_ready;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_mem;
    } vec_t;

    vec_t vecs[9];

    fetch_bus_responder #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_en    (bus_en),
        .bus_addr  (bus_addr),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected outcome derived from the protocol timeline, not from FSM internals
    function automatic vec_t model(input logic [31:0] addr, input int ack, input int drop,
                                   input logic [31:0] rd);
        vec_t v;
        v.addr = addr; v.ack_dly = ack; v.drop = drop; v.rdata = rd;
        v.exp_ready = 0; v.exp_lat = 0; v.exp_err = 1'b0; v.exp_rdata = '0; v.exp_mem = 0;
        if (addr[1:0] != 2'b00) begin
            v.exp_ready = 1; v.exp_lat = 1; v.exp_err = 1'b1;
        end else if (drop > 0 && drop <= WS) begin
            v.exp_mem = 0;
        end else if (ack >= TO) begin
            v.exp_ready = 1; v.exp_lat = WS + TO + 1; v.exp_err = 1'b1; v.exp_mem = TO;
        end else if (drop > 0) begin
            v.exp_mem = ack + 1;
        end else begin
            v.exp_ready = 1; v.exp_lat = WS + ack + 2; v.exp_rdata = rd; v.exp_mem = ack + 1;
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int          nready = 0;
        int          lat = -1;
        int          nmem = 0;
        int          addr_bad = 0;
        int          leak = 0;
        logic        err = 1'b0;
        logic [31:0] rd = '0;
        bus_en   = 1'b1;
        bus_addr = v.addr;
        mem_ack  = 1'b0;
        for (int c = 1; c <= RUN; c++) begin
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (c == v.drop) bus_en = 1'b0;
            bus_addr = $urandom;
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (mem_addr !== v.addr[31:2]) addr_bad++;
                if (nmem == v.ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
                nmem++;
            end else if (mem_addr !== '0) begin
                leak++;
            end
            if (bus_ready === 1'b1) begin
                nready++;
                if (lat < 0) begin
                    lat = c; err = bus_err; rd = bus_rdata;
                end
                bus_en = 1'b0;
            end else if (bus_rdata !== '0 || bus_err !== 1'b0) begin
                leak++;
            end
        end
        mem_ack = 1'b0;
        check({tag, "_nready"}, 64'(nready), 64'(v.exp_ready));
        check({tag, "_memcyc"}, 64'(nmem), 64'(v.exp_mem));
        check({tag, "_memaddr"}, 64'(addr_bad), 64'd0);
        check({tag, "_idle_outs"}, 64'(leak), 64'd0);
        if (v.exp_ready != 0) begin
            check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
            check({tag, "_err"}, 64'(err), 64'(v.exp_err));
            check({tag, "_rdata"}, 64'(rd), 64'(v.exp_rdata));
        end
    endtask

    initial begin
        vec_t v;
        int   ack, drop;
        logic [31:0] a;

        vecs[0] = '{32'h0000_0010, 0, 0, 32'h0000_0013, 1, 4, 1'b0, 32'h0000_0013, 1};
        vecs[1] = '{32'h0000_0012, 0, 0, 32'h1111_1111, 1, 1, 1'b1, 32'h0, 0};
        vecs[2] = '{32'h0000_0020, 0, 2, 32'h2222_2222, 0, 0, 1'b0, 32'h0, 0};
        vecs[3] = '{32'h0000_0030, 3, 3, 32'h3333_3333, 0, 0, 1'b0, 32'h0, 4};
        vecs[4] = '{32'h0000_0040, 99, 0, 32'h4444_4444, 1, 11, 1'b1, 32'h0, 8};
        vecs[5] = '{32'h0000_0044, 7, 0, 32'h5555_5555, 1, 11, 1'b0, 32'h5555_5555, 8};
        vecs[6] = '{32'hFFFF_FFFC, 2, 0, 32'hDEAD_BEEF, 1, 6, 1'b0, 32'hDEAD_BEEF, 3};
        vecs[7] = '{32'h0000_0003, 0, 0, 32'h6666_6666, 1, 1, 1'b1, 32'h0, 0};
        vecs[8] = '{32'h0000_0050, 0, 1, 32'h7777_7777, 0, 0, 1'b0, 32'h0, 0};

        reset = 1'b1; bus_en = 1'b0; bus_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        check("reset_ctl", 64'({bus_ready, bus_err, mem_req}), 64'd0);
        check("reset_data", 64'({bus_rdata, mem_addr}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a memory access
        @(posedge clk); #1;
        bus_en = 1'b1; bus_addr = 32'h0000_0100;
        for (int i = 0; i < 10 && mem_req !== 1'b1; i++) @(negedge clk);
        check("rst_reach_mem", 64'(mem_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_ctl", 64'({bus_ready, bus_err, mem_req}), 64'd0);
        check("rst_async_data", 64'({bus_rdata, mem_addr}), 64'd0);
        @(posedge clk); #1;
        check("rst_held_ctl", 64'({bus_ready, bus_err, mem_req}), 64'd0);
        bus_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_txn(model(32'h0000_0080, 1, 0, 32'h0000_A5A5), "post_rst");

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            ack  = $urandom_range(0, TO + 2);
            drop = 0;
            if (a[1:0] == 2'b00 && $urandom_range(0, 2) == 0) begin
                if (ack >= TO) ack = $urandom_range(0, TO - 1);
                drop = $urandom_range(1, WS + 1 + ack);
            end
            v = model(a, ack, drop, $urandom);
            run_txn(v, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
